// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encoding, WARL masks and interrupt ids for csr_unit.
// Also holds the RW/RS/RC merge helper used by the write path.
package csr_pkg;

  localparam logic [11:0] MSTATUS   = 12'h300;
  localparam logic [11:0] MISA      = 12'h301;
  localparam logic [11:0] MIE       = 12'h304;
  localparam logic [11:0] MTVEC     = 12'h305;
  localparam logic [11:0] MSCRATCH  = 12'h340;
  localparam logic [11:0] MEPC      = 12'h341;
  localparam logic [11:0] MCAUSE    = 12'h342;
  localparam logic [11:0] MTVAL     = 12'h343;
  localparam logic [11:0] MIP       = 12'h344;
  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRETH = 12'hB82;
  localparam logic [11:0] MVENDORID = 12'hF11;
  localparam logic [11:0] MARCHID   = 12'hF12;
  localparam logic [11:0] MIMPID    = 12'hF13;
  localparam logic [11:0] MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_MASK  = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_MASK_V  = 32'hFFFF_FFFD;
  localparam logic [31:0] MTVEC_MASK_NV = 32'hFFFF_FFFC;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  function automatic logic [31:0] csr_wval(csr_op_e op, logic [31:0] old, logic [31:0] wdata);
    case (op)
      CSR_RW:  csr_wval = wdata;
      CSR_RS:  csr_wval = old | wdata;
      CSR_RC:  csr_wval = old & ~wdata;
      default: csr_wval = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter with increment enable and per-32-bit-half overwrite.
// A half write replaces that half on the edge; the other half still sees the increment.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_wr_lo,
  input  logic             i_wr_hi,
  input  logic [31:0]      i_wdata,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt + CNT_W'(i_inc);
    if (i_wr_lo) w_nxt[31:0] = i_wdata;
    // With a 32-bit counter there is no upper half, so high writes are discarded.
    if (i_wr_hi && CNT_W > 32) w_nxt[CNT_W-1 -: 32] = i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: RW/RS/RC access, trap/mret status stack, interrupt arbitration,
// vectored trap target and cycle/instret counters. Reads are combinational.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_v_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            exception_v_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_v_i,
  input  logic            instret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_soft_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? MTVEC_MASK_V : MTVEC_MASK_NV;

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic [CNT_W-1:0] w_mcycle;
  logic [CNT_W-1:0] w_minstret;
  logic [63:0]      w_mcycle64;
  logic [63:0]      w_minstret64;

  csr_op_e         w_op;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_csr_old;
  logic [XLEN-1:0] w_wval;
  logic            w_known;
  logic            w_ro;
  logic            w_is_write;
  logic            w_illegal;
  logic            w_do_write;
  logic [XLEN-1:0] w_irq_act;
  logic [3:0]      w_irq_id;
  logic [XLEN-1:0] w_vec_off;

  assign w_op         = csr_op_e'(csr_op_i);
  assign w_mcycle64   = 64'(w_mcycle);
  assign w_minstret64 = 64'(w_minstret);
  assign w_mstatus    = MSTATUS_MPP | {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  always_comb begin
    w_known   = 1'b1;
    w_csr_old = '0;
    case (csr_adr_i)
      MSTATUS:   w_csr_old = w_mstatus;
      MISA:      w_csr_old = MISA_VAL;
      MIE:       w_csr_old = r_mie;
      MTVEC:     w_csr_old = r_mtvec;
      MSCRATCH:  w_csr_old = r_mscratch;
      MEPC:      w_csr_old = r_mepc;
      MCAUSE:    w_csr_old = r_mcause;
      MTVAL:     w_csr_old = r_mtval;
      MIP:       w_csr_old = r_mip;
      MCYCLE:    w_csr_old = w_mcycle64[31:0];
      MCYCLEH:   w_csr_old = w_mcycle64[63:32];
      MINSTRET:  w_csr_old = w_minstret64[31:0];
      MINSTRETH: w_csr_old = w_minstret64[63:32];
      MVENDORID: w_csr_old = '0;
      MARCHID:   w_csr_old = '0;
      MIMPID:    w_csr_old = '0;
      MHARTID:   w_csr_old = HART_ID;
      default:   w_known   = 1'b0;
    endcase
  end

  // RS/RC with a zero operand only reads, so it stays legal on read-only CSRs.
  assign w_ro       = (csr_adr_i inside {[MVENDORID:MHARTID]}) || (csr_adr_i == MIP);
  assign w_is_write = (w_op == CSR_RW) ||
                      (((w_op == CSR_RS) || (w_op == CSR_RC)) && (csr_wdata_i != '0));
  assign w_illegal  = csr_v_i && (!w_known || (w_is_write && w_ro));
  assign w_do_write = csr_v_i && w_is_write && !w_illegal && !exception_v_i && !mret_v_i;
  assign w_wval     = csr_wval(w_op, w_csr_old, csr_wdata_i);

  assign csr_rdata_o   = w_illegal ? '0 : w_csr_old;
  assign csr_illegal_o = w_illegal;

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (1'b1),
    .i_wr_lo (w_do_write && (csr_adr_i == MCYCLE)),
    .i_wr_hi (w_do_write && (csr_adr_i == MCYCLEH)),
    .i_wdata (csr_wdata_i),
    .o_cnt   (w_mcycle)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (instret_i),
    .i_wr_lo (w_do_write && (csr_adr_i == MINSTRET)),
    .i_wr_hi (w_do_write && (csr_adr_i == MINSTRETH)),
    .i_wdata (csr_wdata_i),
    .o_cnt   (w_minstret)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      r_mip <= {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_soft_i, 3'b0};
      if (exception_v_i) begin
        r_mepc         <= exc_pc_i & MEPC_MASK;
        r_mcause       <= exc_cause_i;
        r_mtval        <= exc_tval_i;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_v_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_do_write) begin
        case (csr_adr_i)
          MSTATUS: begin
            r_mstatus_mie  <= w_wval[3];
            r_mstatus_mpie <= w_wval[7];
          end
          MIE:      r_mie      <= w_wval & MIE_MASK;
          MTVEC:    r_mtvec    <= w_wval & MTVEC_MASK;
          MSCRATCH: r_mscratch <= w_wval;
          MEPC:     r_mepc     <= w_wval & MEPC_MASK;
          MCAUSE:   r_mcause   <= w_wval;
          MTVAL:    r_mtval    <= w_wval;
          default: ;
        endcase
      end
    end
  end

  // Fixed priority MEI > MSI > MTI.
  assign w_irq_act = r_mie & r_mip;
  always_comb begin
    w_irq_id = 4'd0;
    if (w_irq_act[IRQ_MEI])      w_irq_id = IRQ_MEI;
    else if (w_irq_act[IRQ_MSI]) w_irq_id = IRQ_MSI;
    else if (w_irq_act[IRQ_MTI]) w_irq_id = IRQ_MTI;
  end

  assign irq_pending_o = r_mstatus_mie && (w_irq_act != '0);
  assign irq_cause_o   = {1'b1, 27'b0, w_irq_id};

  assign w_vec_off     = {25'b0, exc_cause_i[4:0], 2'b00};
  assign trap_target_o = {r_mtvec[31:2], 2'b00} +
                         ((r_mtvec[0] && exc_cause_i[31]) ? w_vec_off : '0);
  assign mepc_o        = r_mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: an architectural model checked every cycle, plus literal checks.
module tb_csr_unit;

  localparam logic [31:0] HART = 32'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_v_i = 1'b0;
  logic [1:0]  csr_op_i = 2'd0;
  logic [11:0] csr_adr_i = 12'h0;
  logic [31:0] csr_wdata_i = 32'h0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        exception_v_i = 1'b0;
  logic [31:0] exc_cause_i = 32'h0;
  logic [31:0] exc_pc_i = 32'h0;
  logic [31:0] exc_tval_i = 32'h0;
  logic        mret_v_i = 1'b0;
  logic        instret_i = 1'b0;
  logic        irq_ext_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        irq_soft_i = 1'b0;
  logic        irq_pending_o;
  logic [31:0] irq_cause_o;
  logic [31:0] trap_target_o;
  logic [31:0] mepc_o;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  csr_unit #(.HART_ID(HART)) dut (
    .clk(clk), .reset(reset),
    .csr_v_i(csr_v_i), .csr_op_i(csr_op_i), .csr_adr_i(csr_adr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .exception_v_i(exception_v_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .exc_tval_i(exc_tval_i), .mret_v_i(mret_v_i), .instret_i(instret_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
    .irq_pending_o(irq_pending_o), .irq_cause_o(irq_cause_o),
    .trap_target_o(trap_target_o), .mepc_o(mepc_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: mstatus holds only MIE/MPIE (MPP is added on read).
  typedef struct packed {
    logic [31:0] status, mie, mtvec, scratch, mepc, mcause, mtval, mip;
    logic [63:0] cyc, ins;
  } mstate_t;

  mstate_t m;

  function automatic logic m_known(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                     12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input mstate_t s, input logic [11:0] a);
    case (a)
      12'h300: return s.status | 32'h1800;
      12'h301: return 32'h4000_0100;
      12'h304: return s.mie;
      12'h305: return s.mtvec;
      12'h340: return s.scratch;
      12'h341: return s.mepc;
      12'h342: return s.mcause;
      12'h343: return s.mtval;
      12'h344: return s.mip;
      12'hB00: return s.cyc[31:0];
      12'hB80: return s.cyc[63:32];
      12'hB02: return s.ins[31:0];
      12'hB82: return s.ins[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_writes();
    return (csr_op_i == 2'd1) || (csr_op_i != 2'd0 && csr_wdata_i != 32'h0);
  endfunction

  function automatic logic m_illegal();
    return csr_v_i && (!m_known(csr_adr_i) ||
           (m_writes() && (csr_adr_i inside {12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h344})));
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    logic [31:0] old, nv;
    if (reset) return '0;
    n = s;
    n.cyc = s.cyc + 64'd1;
    n.ins = s.ins + 64'(instret_i);
    n.mip = (irq_ext_i ? 32'h800 : 32'h0) | (irq_timer_i ? 32'h80 : 32'h0) |
            (irq_soft_i ? 32'h8 : 32'h0);
    if (exception_v_i) begin
      n.mepc   = exc_pc_i & ~32'h3;
      n.mcause = exc_cause_i;
      n.mtval  = exc_tval_i;
      n.status = s.status[3] ? 32'h80 : 32'h0;
    end else if (mret_v_i) begin
      n.status = 32'h80 | (s.status[7] ? 32'h8 : 32'h0);
    end else if (csr_v_i && m_writes() && !m_illegal()) begin
      old = m_read(s, csr_adr_i);
      nv = (csr_op_i == 2'd1) ? csr_wdata_i :
           (csr_op_i == 2'd2) ? (old | csr_wdata_i) : (old & ~csr_wdata_i);
      case (csr_adr_i)
        12'h300: n.status  = nv & 32'h88;
        12'h304: n.mie     = nv & 32'h888;
        12'h305: n.mtvec   = nv & ~32'h2;
        12'h340: n.scratch = nv;
        12'h341: n.mepc    = nv & ~32'h3;
        12'h342: n.mcause  = nv;
        12'h343: n.mtval   = nv;
        12'hB00: n.cyc[31:0]  = nv;
        12'hB80: n.cyc[63:32] = nv;
        12'hB02: n.ins[31:0]  = nv;
        12'hB82: n.ins[63:32] = nv;
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] act, tgt;
      logic pend;
      chk("m_illegal", {31'b0, csr_illegal_o}, {31'b0, m_illegal()});
      chk("m_rdata", csr_rdata_o, m_illegal() ? 32'h0 : m_read(m, csr_adr_i));
      act  = m.mie & m.mip;
      pend = m.status[3] && (act != 32'h0);
      chk("m_pending", {31'b0, irq_pending_o}, {31'b0, pend});
      if (pend)
        chk("m_cause", irq_cause_o, act[11] ? 32'h8000000B : act[3] ? 32'h80000003 : 32'h80000007);
      tgt = (m.mtvec & ~32'h3) +
            ((m.mtvec[0] && exc_cause_i[31]) ? {25'b0, exc_cause_i[4:0], 2'b00} : 32'h0);
      chk("m_trap_target", trap_target_o, tgt);
      chk("m_mepc", mepc_o, m.mepc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ill);
    csr_v_i = 1'b1; csr_op_i = op; csr_adr_i = adr; csr_wdata_i = wd;
    #1;
    rd = csr_rdata_o;
    ill = csr_illegal_o;
    tick();
    csr_v_i = 1'b0; csr_op_i = 2'd0; csr_wdata_i = 32'h0;
  endtask

  initial begin
    logic [31:0] rd;
    logic ill;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    csr_acc(2'd2, 12'h301, 0, rd, ill); chk("misa", rd, 32'h4000_0100);
    csr_acc(2'd2, 12'h305, 0, rd, ill); chk("mtvec_rst", rd, 32'h0);
    csr_acc(2'd1, 12'hF14, 32'h5, rd, ill); chk("hartid_wr_ill", {31'b0, ill}, 32'h1);
    chk("hartid_wr_rd", rd, 32'h0);
    csr_acc(2'd2, 12'hF14, 0, rd, ill); chk("hartid_rd", rd, 32'h3);
    chk("hartid_rs0_legal", {31'b0, ill}, 32'h0);
    csr_acc(2'd2, 12'h7C0, 0, rd, ill); chk("unknown_ill", {31'b0, ill}, 32'h1);

    instret_i = 1'b1;
    csr_acc(2'd1, 12'h340, 32'hA5A5A5A5, rd, ill);
    csr_acc(2'd2, 12'h340, 32'h0000FFFF, rd, ill); chk("scratch_rw", rd, 32'hA5A5A5A5);
    csr_acc(2'd3, 12'h340, 32'h000000FF, rd, ill); chk("scratch_rs", rd, 32'hA5A5FFFF);
    instret_i = 1'b0;
    csr_acc(2'd2, 12'h340, 0, rd, ill); chk("scratch_rc", rd, 32'hA5A5FF00);
    csr_acc(2'd2, 12'hB02, 0, rd, ill); chk("minstret", rd, 32'h3);
    csr_acc(2'd1, 12'h344, 32'h888, rd, ill); chk("mip_wr_ill", {31'b0, ill}, 32'h1);

    csr_acc(2'd2, 12'h300, 32'h8, rd, ill);
    csr_acc(2'd2, 12'h304, 32'h880, rd, ill);
    irq_timer_i = 1'b1;
    #1 chk("pend_before", {31'b0, irq_pending_o}, 32'h0);
    tick();
    chk("pend_timer", {31'b0, irq_pending_o}, 32'h1);
    chk("cause_timer", irq_cause_o, 32'h80000007);
    irq_ext_i = 1'b1;
    tick();
    chk("cause_ext", irq_cause_o, 32'h8000000B);

    csr_acc(2'd1, 12'h305, 32'h00001001, rd, ill);
    exception_v_i = 1'b1; exc_cause_i = 32'h8000000B; exc_pc_i = 32'h200; exc_tval_i = 32'hDEAD;
    #1 chk("trap_target", trap_target_o, 32'h102C);
    tick();
    exception_v_i = 1'b0;
    chk("mepc_trap", mepc_o, 32'h200);
    csr_acc(2'd2, 12'h300, 0, rd, ill); chk("mstatus_trap", rd, 32'h1880);
    mret_v_i = 1'b1;
    tick();
    mret_v_i = 1'b0;
    csr_acc(2'd2, 12'h300, 0, rd, ill); chk("mstatus_mret", rd, 32'h1888);

    csr_acc(2'd1, 12'hB80, 32'h0, rd, ill);
    csr_acc(2'd1, 12'hB00, 32'hFFFFFFFF, rd, ill);
    csr_acc(2'd2, 12'hB00, 0, rd, ill); chk("mcycle_lo_ff", rd, 32'hFFFFFFFF);
    csr_acc(2'd2, 12'hB80, 0, rd, ill); chk("mcycle_carry_hi", rd, 32'h1);
    csr_acc(2'd2, 12'hB00, 0, rd, ill); chk("mcycle_lo_after", rd, 32'h1);

    exception_v_i = 1'b1; exc_cause_i = 32'h2; exc_pc_i = 32'h303;
    csr_acc(2'd1, 12'hB00, 32'h0, rd, ill); chk("mcycle_exc_rd", rd, 32'h2);
    exception_v_i = 1'b0;
    csr_acc(2'd2, 12'hB00, 0, rd, ill); chk("mcycle_exc_dropped", rd, 32'h3);
    chk("mepc_aligned", mepc_o, 32'h300);
    mret_v_i = 1'b1;
    tick();
    mret_v_i = 1'b0;
    chk("pend_before_reset", {31'b0, irq_pending_o}, 32'h1);

    reset = 1'b1;
    tick();
    chk("pend_reset", {31'b0, irq_pending_o}, 32'h0);
    chk("mepc_reset", mepc_o, 32'h0);
    chk("trap_reset", trap_target_o, 32'h0);
    reset = 1'b0;
    csr_acc(2'd2, 12'hB00, 0, rd, ill); chk("mcycle_reset", rd, 32'h0);
    csr_acc(2'd2, 12'h340, 0, rd, ill); chk("scratch_reset", rd, 32'h0);
    csr_acc(2'd2, 12'h300, 0, rd, ill); chk("mstatus_reset", rd, 32'h1800);
    irq_ext_i = 1'b0; irq_timer_i = 1'b0;
    tick(); tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
